// File: rtl/gol_pkg.sv
// gol_pkg: shared Game of Life grid constants and cursor move encoding
package gol_pkg;
   localparam int GOL_ROWS = 16;
   localparam int GOL_COLS = 16;
   typedef enum logic [2:0] {EV_NONE, EV_UP, EV_DOWN, EV_LEFT, EV_RIGHT} ev_t;
endpackage

// File: rtl/btn_edge.sv
// btn_edge: 2-FF synchronizer plus rising-edge detector for one async button
module btn_edge (
   input  logic Clock,
   input  logic Reset,
   input  logic d,
   output logic pulse
);
   logic sync1, sync2, prev;
   // shift the button through the synchronizer and keep the previous synced value
   always_ff @(posedge Clock)
      if (Reset) {sync1, sync2, prev} <= '0;
      else {sync1, sync2, prev} <= {d, sync1, sync2};
   assign pulse = sync2 & ~prev;
endmodule

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: setup-mode cursor, one-hot selects, toggle pulse and blink strobe
module cursor_ctrl import gol_pkg::*; #(
   parameter int ROWS = GOL_ROWS,
   parameter int COLS = GOL_COLS,
   parameter int BLINK_CYCLES = 8
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic                    setup,
   input  logic                    btn_up,
   input  logic                    btn_down,
   input  logic                    btn_left,
   input  logic                    btn_right,
   input  logic                    btn_toggle,
   output logic [ROWS-1:0]         row_sel,
   output logic [COLS-1:0]         col_sel,
   output logic [$clog2(ROWS)-1:0] cur_row,
   output logic [$clog2(COLS)-1:0] cur_col,
   output logic                    toggle,
   output logic                    blink
);
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam int BW = $clog2(BLINK_CYCLES + 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
   localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
   localparam logic [BW-1:0] CNT_MAX = BW'(BLINK_CYCLES - 1);
   logic [4:0] btn, ev;
   logic [BW-1:0] cnt;
   ev_t row_ev, col_ev;
   assign btn = {btn_toggle, btn_right, btn_left, btn_down, btn_up};
   for (genvar i = 0; i < 5; i++) begin : g_btn
      btn_edge u_edge (.Clock(Clock), .Reset(Reset), .d(btn[i]), .pulse(ev[i]));
   end
   // opposing presses on the same axis cancel out
   always_comb begin
      row_ev = (ev[0] & ~ev[1]) ? EV_UP : (ev[1] & ~ev[0]) ? EV_DOWN : EV_NONE;
      col_ev = (ev[2] & ~ev[3]) ? EV_LEFT : (ev[3] & ~ev[2]) ? EV_RIGHT : EV_NONE;
   end
   // cursor moves and toggle pulse; a toggle discards moves in the same cycle
   always_ff @(posedge Clock)
      if (Reset) begin
         cur_row <= '0;
         cur_col <= '0;
         toggle  <= 1'b0;
      end else begin
         toggle <= setup & ev[4];
         if (setup & ~ev[4]) begin
            if (row_ev == EV_UP) cur_row <= (cur_row == '0) ? ROW_MAX : cur_row - 1'b1;
            else if (row_ev == EV_DOWN) cur_row <= (cur_row == ROW_MAX) ? '0 : cur_row + 1'b1;
            if (col_ev == EV_LEFT) cur_col <= (cur_col == '0) ? COL_MAX : cur_col - 1'b1;
            else if (col_ev == EV_RIGHT) cur_col <= (cur_col == COL_MAX) ? '0 : cur_col + 1'b1;
         end
      end
   // blink half-period counter, held cleared outside setup so it restarts cleanly
   always_ff @(posedge Clock)
      if (Reset || !setup) begin
         cnt   <= '0;
         blink <= 1'b0;
      end else if (cnt == CNT_MAX) begin
         cnt   <= '0;
         blink <= ~blink;
      end else cnt <= cnt + 1'b1;
   assign row_sel = {{(ROWS-1){1'b0}}, 1'b1} << cur_row;
   assign col_sel = {{(COLS-1){1'b0}}, 1'b1} << cur_col;
endmodule

// File: tb/tb_cursor_ctrl.sv
// tb_cursor_ctrl: directed-vector bench for cursor_ctrl
module tb_cursor_ctrl;
   logic Clock = 1'b0, Reset = 1'b1, setup = 1'b0;
   logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_toggle = 1'b0;
   logic [15:0] row_sel, col_sel;
   logic [3:0] cur_row, cur_col;
   logic toggle, blink;
   int vectors = 0, errors = 0;
   int c;
   always #5 Clock = ~Clock;
   cursor_ctrl dut (
      .Clock(Clock), .Reset(Reset), .setup(setup),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
      .btn_right(btn_right), .btn_toggle(btn_toggle),
      .row_sel(row_sel), .col_sel(col_sel), .cur_row(cur_row), .cur_col(cur_col),
      .toggle(toggle), .blink(blink)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(negedge Clock);
   endtask
   task automatic set_btn(input logic [4:0] b);
      {btn_toggle, btn_right, btn_left, btn_down, btn_up} = b;
   endtask
   task automatic press(input logic [4:0] b);
      set_btn(b);
      cyc(1);
      set_btn(5'd0);
      cyc(4);
   endtask
   task automatic count_toggle(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         cyc(1);
         cnt += int'(toggle);
      end
   endtask
   initial begin
      cyc(2);
      Reset = 1'b0;
      check("rst_row", cur_row, 0);
      check("rst_col", cur_col, 0);
      check("rst_row_sel", row_sel, 16'h0001);
      check("rst_col_sel", col_sel, 16'h0001);
      check("rst_toggle", toggle, 0);
      check("rst_blink", blink, 0);
      setup = 1'b1;
      cyc(1);
      set_btn(5'b01000);
      cyc(1);
      check("lat_n", cur_col, 0);
      cyc(1);
      check("lat_n1", cur_col, 0);
      cyc(1);
      check("lat_n2", cur_col, 1);
      cyc(2);
      set_btn(5'd0);
      cyc(4);
      check("held_once", cur_col, 1);
      press(5'b00100);
      check("left_1", cur_col, 0);
      press(5'b00100);
      check("left_wrap", cur_col, 15);
      check("left_wrap_sel", col_sel, 16'h8000);
      for (int i = 1; i <= 16; i++) begin
         press(5'b00010);
         check($sformatf("down_%0d", i), cur_row, i % 16);
         check($sformatf("down_sel_%0d", i), row_sel, 32'h1 << (i % 16));
      end
      press(5'b00001);
      check("up_wrap", cur_row, 15);
      check("up_wrap_sel", row_sel, 16'h8000);
      press(5'b00011);
      check("up_down", cur_row, 15);
      set_btn(5'b11000);
      cyc(1);
      set_btn(5'd0);
      count_toggle(6, c);
      check("tog_right_pulse", c, 1);
      check("tog_right_col", cur_col, 15);
      setup = 1'b0;
      set_btn(5'b11111);
      cyc(1);
      set_btn(5'd0);
      count_toggle(6, c);
      check("nosetup_toggle", c, 0);
      check("nosetup_row", cur_row, 15);
      check("nosetup_col", cur_col, 15);
      check("nosetup_sel", row_sel, 16'h8000);
      check("nosetup_blink", blink, 0);
      set_btn(5'b10000);
      cyc(4);
      setup = 1'b1;
      count_toggle(6, c);
      check("held_setup_edge", c, 0);
      set_btn(5'd0);
      cyc(3);
      setup = 1'b0;
      cyc(2);
      check("blink_off", blink, 0);
      setup = 1'b1;
      cyc(7);
      check("blink_7", blink, 0);
      cyc(1);
      check("blink_8", blink, 1);
      cyc(7);
      check("blink_15", blink, 1);
      cyc(1);
      check("blink_16", blink, 0);
      set_btn(5'b10000);
      cyc(1);
      Reset = 1'b1;
      count_toggle(3, c);
      check("rst_mid_toggle", c, 0);
      check("rst_mid_row", cur_row, 0);
      check("rst_mid_col", cur_col, 0);
      check("rst_mid_row_sel", row_sel, 16'h0001);
      check("rst_mid_col_sel", col_sel, 16'h0001);
      check("rst_mid_blink", blink, 0);
      Reset = 1'b0;
      count_toggle(5, c);
      check("held_past_rst", c, 1);
      set_btn(5'd0);
      cyc(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
